// File: rtl/pim_tile_scheduler.sv
// Per-unit dispatch/accumulate scheduler for tiled PIM matrix multiply: each unit walks its
// K-slices (skipping zero-product ones), accumulates results, and one done pulse ends the run.
module pim_tile_scheduler #(
  parameter int unsigned  WIDTH      = 16,
  parameter int unsigned  NUM_UNITS  = 4,
  parameter int unsigned  TILE_ELEMS = 4,
  parameter int unsigned  NUM_SLICES = 4,
  parameter bit           SKIP_EN    = 1'b1,
  localparam int unsigned SW         = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1,
  localparam int unsigned CW         = $clog2(NUM_UNITS * NUM_SLICES + 1),
  localparam int unsigned DW         = NUM_UNITS * TILE_ELEMS * WIDTH
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_start,
  input  logic                            i_accumulate,
  input  logic [NUM_UNITS*NUM_SLICES-1:0] i_zero_mask,
  output logic [NUM_UNITS-1:0]            o_disp_valid,
  output logic [NUM_UNITS*SW-1:0]         o_disp_slice,
  input  logic [NUM_UNITS-1:0]            i_disp_ready,
  input  logic [NUM_UNITS-1:0]            i_res_valid,
  input  logic [DW-1:0]                   i_res_data,
  output logic [DW-1:0]                   o_acc_out,
  output logic                            o_busy,
  output logic                            o_done,
  output logic [CW-1:0]                   o_skip_count,
  output logic                            o_proto_err
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StFin} unit_state_e;

  unit_state_e           r_state   [NUM_UNITS];
  unit_state_e           w_state_d [NUM_UNITS];
  logic [SW-1:0]         r_slice   [NUM_UNITS];
  logic [SW-1:0]         w_slice_d [NUM_UNITS];
  logic [NUM_SLICES-1:0] r_mask    [NUM_UNITS];

  logic [DW-1:0]        r_acc, w_acc_d;
  logic [CW-1:0]        r_skip_count, w_skip_inc;
  logic                 r_busy, r_done, r_proto_err;
  logic                 w_start, w_all_fin, w_proto_hit;
  logic [NUM_UNITS-1:0] w_skip, w_last;

  assign w_start = i_start && !r_busy;

  always_comb begin
    w_all_fin = 1'b1;
    w_skip    = '0;
    w_last    = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      w_skip[u] = SKIP_EN && r_mask[u][r_slice[u]];
      w_last[u] = (r_slice[u] == SW'(NUM_SLICES - 1));
      if (r_state[u] != StFin) w_all_fin = 1'b0;
    end
  end

  always_comb begin
    w_acc_d     = r_acc;
    w_skip_inc  = '0;
    w_proto_hit = 1'b0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      w_state_d[u] = r_state[u];
      w_slice_d[u] = r_slice[u];
      unique case (r_state[u])
        StIdle: begin
          if (w_start) begin
            w_state_d[u] = StIssue;
            w_slice_d[u] = '0;
          end
        end
        StIssue: begin
          // Skipped slices advance one per cycle and finish exactly like dispatched ones.
          if (w_skip[u]) begin
            w_skip_inc = w_skip_inc + CW'(1);
            if (w_last[u]) w_state_d[u] = StFin;
            else           w_slice_d[u] = r_slice[u] + SW'(1);
          end else if (i_disp_ready[u]) begin
            w_state_d[u] = StWait;
          end
        end
        StWait: begin
          if (i_res_valid[u]) begin
            for (int e = 0; e < TILE_ELEMS; e++) begin
              w_acc_d[(u*TILE_ELEMS+e)*WIDTH +: WIDTH] =
                r_acc[(u*TILE_ELEMS+e)*WIDTH +: WIDTH] +
                i_res_data[(u*TILE_ELEMS+e)*WIDTH +: WIDTH];
            end
            if (w_last[u]) begin
              w_state_d[u] = StFin;
            end else begin
              w_state_d[u] = StIssue;
              w_slice_d[u] = r_slice[u] + SW'(1);
            end
          end
        end
        StFin: begin
          if (w_all_fin) begin
            w_state_d[u] = StIdle;
            w_slice_d[u] = '0;
          end
        end
        default: w_state_d[u] = StIdle;
      endcase
      if (i_res_valid[u] && (r_state[u] != StWait)) w_proto_hit = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        r_state[u] <= StIdle;
        r_slice[u] <= '0;
        r_mask[u]  <= '0;
      end
      r_acc        <= '0;
      r_skip_count <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_proto_err  <= 1'b0;
    end else begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        r_state[u] <= w_state_d[u];
        r_slice[u] <= w_slice_d[u];
      end
      r_done      <= w_all_fin;
      r_proto_err <= r_proto_err | w_proto_hit;
      if (r_done) begin
        r_busy       <= 1'b0;
        r_acc        <= w_acc_d;
        r_skip_count <= r_skip_count + w_skip_inc;
      end else if (w_start) begin
        for (int u = 0; u < NUM_UNITS; u++) begin
          r_mask[u] <= i_zero_mask[u*NUM_SLICES +: NUM_SLICES];
        end
        r_busy       <= 1'b1;
        r_skip_count <= '0;
        r_acc        <= i_accumulate ? w_acc_d : '0;
      end else begin
        r_acc        <= w_acc_d;
        r_skip_count <= r_skip_count + w_skip_inc;
      end
    end
  end

  always_comb begin
    o_disp_valid = '0;
    o_disp_slice = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      o_disp_valid[u]           = (r_state[u] == StIssue) && !w_skip[u];
      o_disp_slice[u*SW +: SW]  = r_slice[u];
    end
  end

  assign o_acc_out    = r_acc;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_skip_count = r_skip_count;
  assign o_proto_err  = r_proto_err;

endmodule

// File: tb/tb_pim_tile_scheduler.sv
// Directed bench for pim_tile_scheduler: a built-in unit model answers each dispatch two
// cycles later with a per-unit/per-slice value from a table; expectations are hand-computed.
module tb_pim_tile_scheduler;

  localparam int W  = 16;
  localparam int U  = 4;
  localparam int TE = 4;
  localparam int S  = 4;
  localparam int SW = 2;
  localparam int CW = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              accumulate;
  logic [U*S-1:0]    zero_mask;
  logic [U-1:0]      disp_valid;
  logic [U*SW-1:0]   disp_slice;
  logic [U-1:0]      disp_ready;
  logic [U-1:0]      res_valid;
  logic [U*TE*W-1:0] res_data;
  logic [U*TE*W-1:0] acc_out;
  logic              busy;
  logic              done;
  logic [CW-1:0]     skip_count;
  logic              proto_err;

  pim_tile_scheduler #(
    .WIDTH      (W),
    .NUM_UNITS  (U),
    .TILE_ELEMS (TE),
    .NUM_SLICES (S),
    .SKIP_EN    (1'b1)
  ) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_accumulate (accumulate),
    .i_zero_mask  (zero_mask),
    .o_disp_valid (disp_valid),
    .o_disp_slice (disp_slice),
    .i_disp_ready (disp_ready),
    .i_res_valid  (res_valid),
    .i_res_data   (res_data),
    .o_acc_out    (acc_out),
    .o_busy       (busy),
    .o_done       (done),
    .o_skip_count (skip_count),
    .o_proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  int          n_checks;
  int          n_errors;
  logic [15:0] tab [U][S];
  int          pend [U];
  int          pslice [U];
  int          hs_slice [U];
  int          hs_cnt [U];
  bit [U-1:0]  hs;
  bit          resp_en;
  int          done_cnt;
  int          dv_cnt;
  logic        done_s;
  logic        busy_s;
  logic [U-1:0]    dv_s;
  logic [U*SW-1:0] ds_s;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sample mid-cycle, then after the edge play the unit model for the next cycle.
  task automatic tick();
    @(negedge clk);
    done_s = done;
    busy_s = busy;
    dv_s   = disp_valid;
    ds_s   = disp_slice;
    if (done) done_cnt++;
    if (disp_valid != '0) dv_cnt++;
    for (int u = 0; u < U; u++) begin
      hs[u] = disp_valid[u] && disp_ready[u];
      if (hs[u]) begin
        hs_cnt[u]++;
        hs_slice[u] = int'(disp_slice[u*SW +: SW]);
      end
    end
    @(posedge clk);
    #1;
    if (resp_en) begin
      for (int u = 0; u < U; u++) begin
        res_valid[u] = 1'b0;
        if (pend[u] != 0) begin
          res_valid[u] = 1'b1;
          for (int e = 0; e < TE; e++) res_data[(u*TE+e)*W +: W] = tab[u][pslice[u]];
          pend[u] = 0;
        end
        if (hs[u]) begin
          pend[u]   = 1;
          pslice[u] = hs_slice[u];
        end
      end
    end
  endtask

  task automatic fill_tab(input logic [15:0] v);
    for (int u = 0; u < U; u++)
      for (int s = 0; s < S; s++) tab[u][s] = v;
  endtask

  task automatic do_start(input logic acc, input logic [U*S-1:0] mask);
    accumulate = acc;
    zero_mask  = mask;
    start      = 1'b1;
    done_cnt   = 0;
    dv_cnt     = 0;
    for (int u = 0; u < U; u++) hs_cnt[u] = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_done(input string tag, output int cyc);
    cyc = -1;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (done_s === 1'b1) begin
        cyc = k;
        break;
      end
    end
    check_eq({tag, "_done_seen"}, 32'(done_s), 32'd1);
    check_eq({tag, "_busy_at_done"}, 32'(busy_s), 32'd1);
    tick();
    check_eq({tag, "_busy_after"}, 32'(busy_s), 32'd0);
    tick();
    tick();
    check_eq({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
  endtask

  task automatic check_acc(input string tag, input int e0, input int e1, input int e2,
                           input int e3);
    int exp [U];
    exp[0] = e0;
    exp[1] = e1;
    exp[2] = e2;
    exp[3] = e3;
    for (int u = 0; u < U; u++)
      for (int e = 0; e < TE; e++)
        check_eq($sformatf("%s_acc_u%0d_e%0d", tag, u, e),
                 32'(acc_out[(u*TE+e)*W +: W]), exp[u]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int bad;
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    accumulate = 1'b0;
    zero_mask  = '0;
    disp_ready = '1;
    res_valid  = '0;
    res_data   = '0;
    resp_en    = 1'b1;
    hs         = '0;
    for (int u = 0; u < U; u++) begin
      pend[u]     = 0;
      pslice[u]   = 0;
      hs_slice[u] = 0;
      hs_cnt[u]   = 0;
    end
    fill_tab(16'd0);
    tick();
    tick();

    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_disp_valid", 32'(disp_valid), 32'd0);
    check_eq("rst_disp_slice", 32'(disp_slice), 32'd0);
    check_eq("rst_skip", 32'(skip_count), 32'd0);
    check_eq("rst_proto", 32'(proto_err), 32'd0);
    check_acc("rst", 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();

    // Plain run: four slices of all-ones per unit.
    fill_tab(16'd1);
    do_start(1'b0, '0);
    run_to_done("t1", cyc);
    check_acc("t1", 4, 4, 4, 4);
    check_eq("t1_skip", 32'(skip_count), 32'd0);
    check_eq("t1_disp_total", 32'(hs_cnt[0] + hs_cnt[1] + hs_cnt[2] + hs_cnt[3]), 32'd16);

    // Everything skipped: no dispatch, done in cycle NUM_SLICES+1.
    do_start(1'b0, '1);
    run_to_done("t2", cyc);
    check_eq("t2_done_cycle", 32'(cyc), 32'd5);
    check_eq("t2_dv_cycles", 32'(dv_cnt), 32'd0);
    check_eq("t2_skip", 32'(skip_count), 32'd16);
    check_acc("t2", 0, 0, 0, 0);

    // Last slice of unit 2 skipped.
    for (int s = 0; s < S; s++) begin
      tab[0][s] = 16'(s + 1);
      tab[1][s] = 16'd5;
      tab[2][s] = 16'(10 * (s + 1));
      tab[3][s] = 16'(256 * (s + 1));
    end
    do_start(1'b0, 16'h0800);
    run_to_done("t3", cyc);
    check_eq("t3_skip", 32'(skip_count), 32'd1);
    check_eq("t3_u2_disp", 32'(hs_cnt[2]), 32'd3);
    check_acc("t3", 10, 20, 60, 32'h0A00);

    // Backpressure on unit 0, ignored mid-run start, wrapping accumulation.
    fill_tab(16'd1);
    tab[0][0] = 16'hFFFF;
    tab[0][1] = 16'h0002;
    tab[0][2] = 16'h0000;
    tab[0][3] = 16'h0000;
    disp_ready = 4'b1110;
    do_start(1'b0, '0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        start     = 1'b1;
        zero_mask = '1;
      end else begin
        start = 1'b0;
      end
      tick();
      if (!(dv_s[0] === 1'b1 && ds_s[SW-1:0] === 2'd0)) bad++;
    end
    start     = 1'b0;
    zero_mask = '0;
    check_eq("t4_hold_bad_cycles", 32'(bad), 32'd0);
    check_eq("t4_busy_mid", 32'(busy_s), 32'd1);
    disp_ready = '1;
    run_to_done("t4", cyc);
    check_eq("t4_skip", 32'(skip_count), 32'd0);
    check_acc("t4", 1, 4, 4, 4);

    // K-split across runs.
    fill_tab(16'd3);
    do_start(1'b0, '0);
    run_to_done("t5a", cyc);
    check_acc("t5a", 12, 12, 12, 12);
    fill_tab(16'd5);
    do_start(1'b1, 16'h000F);
    run_to_done("t5b", cyc);
    check_eq("t5b_skip", 32'(skip_count), 32'd4);
    check_acc("t5b", 12, 32, 32, 32);
    fill_tab(16'd7);
    do_start(1'b0, '0);
    run_to_done("t5c", cyc);
    check_acc("t5c", 28, 28, 28, 28);

    // Reset while units wait for results, then a spurious result while idle.
    fill_tab(16'd1);
    do_start(1'b1, '0);
    for (int k = 0; k < 20; k++) begin
      tick();
      if (hs[0]) break;
    end
    check_eq("t6_hs_seen", 32'(hs[0]), 32'd1);
    check_eq("t6_pre_acc", 32'(acc_out[W-1:0]), 32'd28);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_busy", 32'(busy), 32'd0);
    check_eq("t6_rst_disp_valid", 32'(disp_valid), 32'd0);
    check_eq("t6_rst_skip", 32'(skip_count), 32'd0);
    check_acc("t6_rst", 0, 0, 0, 0);
    for (int u = 0; u < U; u++) pend[u] = 0;
    res_valid = '0;
    tick();
    rst_n    = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 10; k++) tick();
    check_eq("t6_no_done", 32'(done_cnt), 32'd0);
    check_eq("t6_proto_clear", 32'(proto_err), 32'd0);
    resp_en   = 1'b0;
    res_data  = '1;
    res_valid = 4'b0010;
    tick();
    res_valid = '0;
    tick();
    check_eq("t6_proto_set", 32'(proto_err), 32'd1);
    check_eq("t6_spurious_ignored", 32'(acc_out[(1*TE)*W +: W]), 32'd0);
    tick();
    check_eq("t6_proto_sticky", 32'(proto_err), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
